console_arbiter: RTL
====================

Name: console_arbiter

Overview:
- Shares the single simulation console device (char-out at offset 0x04, sim-control/halt at offset 0x08) between NumReq bus requesters, e.g. multiple harts or a hart plus a debug master.
- Arbitration is round-robin, with registered outputs toward the console.
- An optional line lock keeps one requester's characters contiguous until it writes a newline, so console/log lines never interleave.

Parameters:
- NumReq, 2, number of requesters (2..8).
- LockTimeout, 256, cycles with no owner request before a line lock is force-released (>=2).
- CharOutOfs, 8'h04, addr[7:0] offset of the character-output register.
- SimCtrlOfs, 8'h08, addr[7:0] offset of the sim-control (halt) register.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NumReq  per-requester access request; held until granted.
- we_i  in  NumReq  per-requester write enable.
- addr_i  in  NumReq*32  per-requester address; slice k = [32k+31:32k].
- wdata_i  in  NumReq*32  per-requester write data; same slicing.
- gnt_o  out  NumReq  one-cycle pulse: the access was forwarded this cycle.
- con_req_o  out  1  request to console.
- con_we_o  out  1  write enable to console.
- con_addr_o  out  32  address to console.
- con_wdata_o  out  32  write data to console.
- lock_valid_o  out  1  a line lock is held.
- lock_owner_o  out  3  index of the lock owner; 0 when no lock is held.

Behaviour:
- Reset (rst_i=1 at a posedge):
  - gnt_o, con_req_o, con_we_o, con_addr_o, con_wdata_o, lock_valid_o, lock_owner_o all 0.
  - State IDLE, timeout counter 0.
  - RR pointer = NumReq-1, so requester 0 wins first.
  - Reset mid-lock or mid-grant drops everything; no partial access completes.
- Eligibility, evaluated each cycle: requester k is eligible if req_i[k]=1 AND gnt_o[k]=0. Requester k is ignored in the cycle after its grant, which prevents double issue; it must drop req_i or present a new access in that cycle.
- IDLE:
  - Winner = first eligible index searching from pointer+1 with wrap-around; pointer <= winner.
  - Next cycle: gnt_o[winner]=1, and con_* = winner's we/addr/wdata with con_req_o=1.
  - Latency: request sampled at edge T, console sees it from T+1 for exactly one cycle.
  - With no eligible requester, con_req_o=0 and con_* data holds its last value.
- Lock entry: a granted write to CharOutOfs with wdata[7:0] != 8'h0A moves the arbiter to LOCKED, owner = winner, counter cleared.
- LOCKED:
  - Only the owner is eligible; all other requests stall, held.
  - Owner write to CharOutOfs with wdata[7:0]==8'h0A is forwarded, then the arbiter returns to IDLE.
  - Any other owner access (reads, SimCtrlOfs writes, other offsets) is forwarded and the lock is kept.
  - Counter increments in each cycle the owner is not eligible and clears on each owner grant. When the counter reaches LockTimeout-1, the arbiter returns to IDLE next cycle with no access issued.
  - A non-owner SimCtrlOfs write waits for lock release; halt is never reordered ahead of a pending line.
- Simultaneous events:
  - The lock releases and a new winner is selected in the same cycle the newline is forwarded; the next grant may issue at T+2.
  - Release takes priority over timeout when both occur together.
- Reads: forwarded unchanged (the console ignores them) and never affect the lock.
- Addresses are forwarded at full 32 bits; only addr[7:0] is decoded for lock purposes.

Optional Feature:
- CONSOLE_ARB_LINE_LOCK_EN defined: line lock, timeout counter and LOCKED state implemented as described.
- Undefined: pure round-robin, state never leaves IDLE, lock_valid_o and lock_owner_o tied 0, LockTimeout unused.

Test Plan:
- Reset, then req_i=2'b11 with both writing CharOutOfs ('A'=0x41, 'B'=0x42), macro undefined -> grants alternate 0,1,0,1; con_wdata_o sequence 0x41,0x42,0x41,0x42; no two grants to the same requester in consecutive cycles.
- Macro defined: req0 writes "hi\n" (0x68,0x69,0x0A) while req1 repeatedly writes 0x58 -> console receives 0x68,0x69,0x0A before any 0x58; lock_valid_o=1 and lock_owner_o=0 between 0x68 and 0x0A.
- Macro defined, LockTimeout=8: req0 writes 0x41 then goes idle, req1 pending -> lock_valid_o drops 8 cycles after req0's grant, then req1 is granted.
- Macro defined: req1 holds the lock, req0 writes 1 to SimCtrlOfs -> the halt write reaches the console only after req1's 0x0A.
- Assert rst_i for 1 cycle while LOCKED with a grant pending -> all outputs 0 next cycle; first post-reset grant goes to requester 0 when both request.
- Reads interleaved: req0 read at CharOutOfs -> forwarded with con_we_o=0; lock_valid_o stays 0.

Source files
------------

// File: rtl/console_arbiter.sv
// console_arbiter
//
// Shares one simulation console device between NumReq bus requesters. The
// console has a character-output register at CharOutOfs and a sim-control
// (halt) register at SimCtrlOfs. Requesters are served round-robin. Every
// access is forwarded through registered outputs, one cycle after it is
// selected.
//
// Build option: define CONSOLE_ARB_LINE_LOCK_EN to add the line lock. A
// requester that writes a non-newline character then owns the console until
// it writes a newline, or until it has been idle for LockTimeout cycles.
// Without the macro the arbiter is purely round-robin and the lock outputs
// are tied to 0.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_i            per-requester request, held until granted
//   we_i             per-requester write enable
//   addr_i, wdata_i  per-requester address / write data, slice k = [32k+31:32k]
//   gnt_o            one-cycle pulse, the requester's access is on the console now
//   con_req_o        access valid toward the console
//   con_we_o         write enable toward the console
//   con_addr_o       address toward the console
//   con_wdata_o      write data toward the console
//   lock_valid_o     a line lock is held
//   lock_owner_o     index of the lock owner, 0 when no lock is held
module console_arbiter #(
    parameter int          NumReq      = 2,
    parameter int          LockTimeout = 256,
    parameter logic [7:0]  CharOutOfs  = 8'h04,
    parameter logic [7:0]  SimCtrlOfs  = 8'h08
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumReq-1:0]    req_i,
    input  logic [NumReq-1:0]    we_i,
    input  logic [NumReq*32-1:0] addr_i,
    input  logic [NumReq*32-1:0] wdata_i,
    output logic [NumReq-1:0]    gnt_o,
    output logic                 con_req_o,
    output logic                 con_we_o,
    output logic [31:0]          con_addr_o,
    output logic [31:0]          con_wdata_o,
    output logic                 lock_valid_o,
    output logic [2:0]           lock_owner_o
);

    localparam int IdxW = $clog2(NumReq);

    logic [NumReq-1:0] elig;
    logic [IdxW-1:0]   ptr;
    logic [IdxW-1:0]   cand;
    logic [IdxW-1:0]   win_idx;
    logic              win_valid;
    logic              win_we;
    logic [31:0]       win_addr;
    logic [31:0]       win_wdata;

`ifdef CONSOLE_ARB_LINE_LOCK_EN
    localparam int CntW = $clog2(LockTimeout);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IdxW-1:0] owner;
    logic [IdxW-1:0] owner_nxt;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cnt_nxt;
    logic            win_char;
    logic            win_opens_line;
    logic            win_ends_line;

    // A requester is skipped in the cycle after its grant so the same access
    // is never issued twice. While a line is locked only the owner may win.
    always_comb begin
        elig = req_i & ~gnt_o;
        if (state == LOCKED) begin
            elig = elig & (NumReq'(1) << owner);
        end
    end
`else
    // A requester is skipped in the cycle after its grant so the same access
    // is never issued twice.
    always_comb begin
        elig = req_i & ~gnt_o;
    end
`endif

    // Round-robin search: the first eligible requester after the last winner,
    // wrapping around.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr;
        cand      = '0;
        for (int i = 1; i <= NumReq; i++) begin
            cand = IdxW'((int'(ptr) + i) % NumReq);
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_we    = we_i[win_idx];
    assign win_addr  = addr_i[32*int'(win_idx) +: 32];
    assign win_wdata = wdata_i[32*int'(win_idx) +: 32];

    // Registered console port. The data fields keep their last value when
    // nothing is forwarded, so only con_req_o says whether they are live.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_o       <= '0;
            con_req_o   <= 1'b0;
            con_we_o    <= 1'b0;
            con_addr_o  <= '0;
            con_wdata_o <= '0;
            ptr         <= IdxW'(NumReq - 1);
        end else begin
            gnt_o     <= '0;
            con_req_o <= 1'b0;
            if (win_valid) begin
                gnt_o       <= NumReq'(1) << win_idx;
                con_req_o   <= 1'b1;
                con_we_o    <= win_we;
                con_addr_o  <= win_addr;
                con_wdata_o <= win_wdata;
                ptr         <= win_idx;
            end
        end
    end

`ifdef CONSOLE_ARB_LINE_LOCK_EN
    // Only a character write can open or close a line. A sim-control write
    // never counts as one, even if the two offsets were set equal.
    assign win_char       = win_we && (win_addr[7:0] == CharOutOfs)
                                   && (win_addr[7:0] != SimCtrlOfs);
    assign win_opens_line = win_char && (win_wdata[7:0] != 8'h0A);
    assign win_ends_line  = win_char && (win_wdata[7:0] == 8'h0A);

    // Lock state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Lock transitions. The newline is forwarded on the same edge that drops
    // the lock, so another requester can be selected in the following cycle.
    // The idle counter runs only while the owner is not eligible. Release is
    // checked before timeout. The two cannot coincide, because a release
    // needs an owner grant and the timeout needs the owner to be idle.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (win_valid && win_opens_line) begin
                    state_nxt = LOCKED;
                    owner_nxt = win_idx;
                    cnt_nxt   = '0;
                end
            end
            LOCKED: begin
                if (win_valid) begin
                    cnt_nxt = '0;
                    if (win_ends_line) begin
                        state_nxt = IDLE;
                        owner_nxt = '0;
                    end
                end else if (cnt == CntW'(LockTimeout - 1)) begin
                    state_nxt = IDLE;
                    owner_nxt = '0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign lock_valid_o = (state == LOCKED);
    assign lock_owner_o = 3'(owner);
`else
    assign lock_valid_o = 1'b0;
    assign lock_owner_o = 3'd0;
`endif

endmodule
